room_draw_controller: RTL and testbench
=======================================

ROOM_DRAW_CONTROLLER -- requirements
Module: room_draw_controller

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 16: cycles clearinitsignal is held after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023: max cycles waiting for draw_done.
REQ-003 SHALL have ports: clock  in  1  single system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-005 cmd_valid  in  1  command request (keyboard/switch event).
REQ-006 cmd_func  in  1  1 = L (lock), 0 = D (unlock).
REQ-007 cmd_room  in  3  room number; 0-4 valid.
REQ-008 draw_done  in  1  single-cycle pulse from VGA drawer: sprite finished.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 loadenable  out  1  datapath load strobe.
REQ-011 enable  out  5  one-hot room enable to datapath (bit r = enable<r>).
REQ-012 clearinitsignal  out  1  datapath coordinate clear.
REQ-013 sel_room  out  3 / sel_func  out  1  latched command, driven to datapath selsw/keyboardin.
REQ-014 draw_start  out  1  one-cycle pulse to VGA drawer.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 lock_state  out  5  bit r = room r locked.
REQ-017 all_locked  out  1  equals &lock_state.
REQ-018 all_locked_pulse  out  1  one-cycle pulse when all_locked rises (audio trigger).
REQ-019 err_room / err_timeout  out  1 each  one-cycle error pulses.

Function
REQ-020 States SHALL be INIT_CLEAR, IDLE, LOAD, ENABLE, DRAW, UPDATE; exactly one active.
REQ-021 INIT_CLEAR: clearinitsignal=1 for exactly CLEAR_CYCLES cycles, then IDLE; cmd_valid ignored.
REQ-022 IDLE: cmd_valid=1 with cmd_room<=4 -> latch cmd_room/cmd_func into sel_room/sel_func, go LOAD next cycle.
REQ-023 IDLE: cmd_valid=1 with cmd_room>4 -> err_room pulse next cycle, stay IDLE, sel_* unchanged.
REQ-024 cmd_valid while cmd_ready=0 SHALL be dropped with no side effect (no queuing).
REQ-025 LOAD: loadenable=1 for exactly 1 cycle, then ENABLE.
REQ-026 ENABLE: enable[sel_room]=1, other bits 0, for exactly 2 cycles (datapath coordsel register + mux latency), then DRAW.
REQ-027 DRAW: draw_start=1 on first DRAW cycle only; enable[sel_room] stays 1 throughout DRAW; 16-bit wait counter starts at 0.
REQ-028 DRAW exit: draw_done=1 -> UPDATE; counter reaching TIMEOUT_CYCLES without draw_done -> err_timeout pulse, go IDLE, lock_state unchanged.
REQ-029 draw_done on the same cycle as timeout SHALL count as done (no error).
REQ-030 draw_done outside DRAW SHALL be ignored.
REQ-031 UPDATE (1 cycle): lock_state[sel_room] <= sel_func; then IDLE.
REQ-032 all_locked_pulse SHALL assert the cycle after lock_state becomes 5'b11111 from any other value; never on reset.
REQ-033 sel_room/sel_func SHALL remain stable from latch until next accepted command.
REQ-034 Command-to-draw_start latency SHALL be 4 cycles (accept edge -> LOAD -> ENABLE x2 -> DRAW).
REQ-035 enable SHALL be 0 in INIT_CLEAR, IDLE, LOAD, UPDATE; loadenable and clearinitsignal never high together.

Reset
REQ-036 reset low SHALL, asynchronously, force state INIT_CLEAR, clear-cycle and wait counters 0, lock_state 0, sel_room 0, sel_func 0, all pulses/enables/loadenable 0, busy 1, cmd_ready 0.
REQ-037 clearinitsignal SHALL be 1 during reset and for CLEAR_CYCLES cycles after release.
REQ-038 reset low mid-DRAW SHALL abort with no lock_state update and no error pulse.

Verification
REQ-039 Release reset, CLEAR_CYCLES=16 -> clearinitsignal high 16 cycles, cmd_ready rises cycle 17; cmd_valid at cycle 5 ignored.
REQ-040 cmd room 3, func L; draw_done 10 cycles after draw_start -> loadenable 1 cycle, enable=5'b01000 from 2 cycles before draw_start through DRAW, lock_state=5'b01000.
REQ-041 cmd_room=6 in IDLE -> err_room single pulse, no loadenable, state IDLE.
REQ-042 TIMEOUT_CYCLES=8, no draw_done -> err_timeout pulse after 8 DRAW cycles, lock_state unchanged, cmd_ready 1 next cycle.
REQ-043 Lock rooms 0-4 sequentially -> all_locked_pulse exactly once after room 4 UPDATE; subsequent D on room 2 -> all_locked 0, no pulse.
REQ-044 cmd_valid asserted during DRAW, and reset asserted mid-DRAW -> command dropped; outputs at REQ-036 values immediately on reset.

Source files
------------

// File: rtl/room_draw_controller.sv
// Sequencer for the room-lock display. Each accepted lock/unlock command loads the datapath
// and enables the selected room, then waits for the VGA drawer before recording the lock state.
module room_draw_controller #(
  parameter int CLEAR_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_func,
  input  logic [2:0] cmd_room,
  input  logic       draw_done,
  output logic       cmd_ready,
  output logic       loadenable,
  output logic [4:0] enable,
  output logic       clearinitsignal,
  output logic [2:0] sel_room,
  output logic       sel_func,
  output logic       draw_start,
  output logic       busy,
  output logic [4:0] lock_state,
  output logic       all_locked,
  output logic       all_locked_pulse,
  output logic       err_room,
  output logic       err_timeout
);

  localparam logic [15:0] CLEAR_LAST   = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT_CLEAR,
    S_IDLE,
    S_LOAD,
    S_ENABLE,
    S_DRAW,
    S_UPDATE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sel_room_q, sel_room_d;
  logic        sel_func_q, sel_func_d;
  logic [4:0]  lock_q, lock_d;
  logic        err_room_q, err_room_d;
  logic        all_prev_q, all_prev_d;
  logic        pulse_q, pulse_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT_CLEAR;
      cnt_q      <= '0;
      sel_room_q <= '0;
      sel_func_q <= 1'b0;
      lock_q     <= '0;
      err_room_q <= 1'b0;
      all_prev_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_room_q <= sel_room_d;
      sel_func_q <= sel_func_d;
      lock_q     <= lock_d;
      err_room_q <= err_room_d;
      all_prev_q <= all_prev_d;
      pulse_q    <= pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    sel_room_d  = sel_room_q;
    sel_func_d  = sel_func_q;
    lock_d      = lock_q;
    err_room_d  = 1'b0;
    err_timeout = 1'b0;
    // Rising edge of the all-locked condition, delayed one cycle for the audio trigger
    all_prev_d  = &lock_q;
    pulse_d     = (&lock_q) & ~all_prev_q;

    case (state_q)
      S_INIT_CLEAR: begin
        if (cnt_q == CLEAR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          if (cmd_room <= 3'd4) begin
            sel_room_d = cmd_room;
            sel_func_d = cmd_func;
            state_d    = S_LOAD;
          end else begin
            err_room_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_ENABLE;
        cnt_d   = '0;
      end
      // Two cycles cover the datapath coordinate-select register plus mux latency
      S_ENABLE: begin
        if (cnt_q == 16'd1) begin
          state_d = S_DRAW;
          cnt_d   = '0;
        end
      end
      S_DRAW: begin
        if (draw_done) begin
          state_d = S_UPDATE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end
      end
      S_UPDATE: begin
        lock_d[sel_room_q] = sel_func_q;
        state_d            = S_IDLE;
        cnt_d              = '0;
      end
      default: begin
        state_d = S_INIT_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = ~cmd_ready;
  assign loadenable       = (state_q == S_LOAD);
  assign clearinitsignal  = (state_q == S_INIT_CLEAR);
  assign enable           = ((state_q == S_ENABLE) || (state_q == S_DRAW)) ? (5'b00001 << sel_room_q) : 5'd0;
  assign draw_start       = (state_q == S_DRAW) && (cnt_q == 16'd0);
  assign sel_room         = sel_room_q;
  assign sel_func         = sel_func_q;
  assign lock_state       = lock_q;
  assign all_locked       = &lock_q;
  assign all_locked_pulse = pulse_q;
  assign err_room         = err_room_q;

endmodule

// File: tb/tb_room_draw_controller.sv
// Bench for room_draw_controller: two instances (short and default timeout) share one stimulus
// stream; a timeline model predicts every output each cycle, backed by literal spot values.
module tb_room_draw_controller;

  localparam int CLR  = 16;
  localparam int TO_A = 8;
  localparam int TO_B = 1023;

  localparam int P_INIT = 0;
  localparam int P_IDLE = 1;
  localparam int P_LOAD = 2;
  localparam int P_EN   = 3;
  localparam int P_DRAW = 4;
  localparam int P_UPD  = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_func = 1'b0;
  logic [2:0] cmd_room = 3'd0;
  logic       draw_done = 1'b0;

  logic       o_ready[2], o_busy[2], o_load[2], o_clr[2], o_start[2], o_sfunc[2];
  logic       o_all[2], o_pulse[2], o_erm[2], o_eto[2];
  logic [4:0] o_en[2], o_lock[2];
  logic [2:0] o_sroom[2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int pulse_cnt[2];

  always #5 clock = ~clock;

  room_draw_controller #(.CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_func(cmd_func),
    .cmd_room(cmd_room), .draw_done(draw_done), .cmd_ready(o_ready[0]),
    .loadenable(o_load[0]), .enable(o_en[0]), .clearinitsignal(o_clr[0]),
    .sel_room(o_sroom[0]), .sel_func(o_sfunc[0]), .draw_start(o_start[0]),
    .busy(o_busy[0]), .lock_state(o_lock[0]), .all_locked(o_all[0]),
    .all_locked_pulse(o_pulse[0]), .err_room(o_erm[0]), .err_timeout(o_eto[0])
  );

  room_draw_controller #(.CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_func(cmd_func),
    .cmd_room(cmd_room), .draw_done(draw_done), .cmd_ready(o_ready[1]),
    .loadenable(o_load[1]), .enable(o_en[1]), .clearinitsignal(o_clr[1]),
    .sel_room(o_sroom[1]), .sel_func(o_sfunc[1]), .draw_start(o_start[1]),
    .busy(o_busy[1]), .lock_state(o_lock[1]), .all_locked(o_all[1]),
    .all_locked_pulse(o_pulse[1]), .err_room(o_erm[1]), .err_timeout(o_eto[1])
  );

  // Timeline model: m_n counts clock edges since reset release; a transaction is
  // described by the cycle of its load strobe (m_s) and the cycle draw_done arrived (m_e).
  int         m_n;
  bit         m_txn[2];
  int         m_s[2];
  int         m_e[2];
  logic [2:0] m_room[2];
  logic       m_func[2];
  logic [4:0] m_lock[2];
  logic       m_erp[2];
  logic       m_prev[2];
  logic       m_pulse[2];

  function automatic int tmo(input int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  function automatic int phase(input int i);
    int d;
    if (m_n < CLR) return P_INIT;
    if (!m_txn[i]) return P_IDLE;
    d = m_n - m_s[i];
    if (d == 0) return P_LOAD;
    if (d <= 2) return P_EN;
    if (m_e[i] >= 0) return P_UPD;
    return P_DRAW;
  endfunction

  function automatic logic [22:0] expv(input int i);
    int         p;
    int         dn;
    logic [4:0] en;
    p  = phase(i);
    dn = m_n - (m_s[i] + 3);
    en = ((p == P_EN) || (p == P_DRAW)) ? (5'b00001 << m_room[i]) : 5'd0;
    return {p == P_IDLE, p != P_IDLE, p == P_LOAD, en, p == P_INIT, m_room[i], m_func[i],
            (p == P_DRAW) && (dn == 0), m_lock[i], &m_lock[i], m_pulse[i], m_erp[i],
            (p == P_DRAW) && !draw_done && (dn == tmo(i) - 1)};
  endfunction

  function automatic logic [22:0] obsv(input int i);
    return {o_ready[i], o_busy[i], o_load[i], o_en[i], o_clr[i], o_sroom[i], o_sfunc[i],
            o_start[i], o_lock[i], o_all[i], o_pulse[i], o_erm[i], o_eto[i]};
  endfunction

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_n = 0;
      for (int i = 0; i < 2; i++) begin
        m_txn[i] = 1'b0; m_s[i] = 0; m_e[i] = -1; m_room[i] = 3'd0; m_func[i] = 1'b0;
        m_lock[i] = 5'd0; m_erp[i] = 1'b0; m_prev[i] = 1'b0; m_pulse[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int p;
        p = phase(i);
        m_pulse[i] = (&m_lock[i]) && !m_prev[i];
        m_prev[i]  = &m_lock[i];
        m_erp[i]   = 1'b0;
        if (p == P_IDLE && cmd_valid) begin
          if (cmd_room <= 3'd4) begin
            m_txn[i] = 1'b1; m_s[i] = m_n + 1; m_e[i] = -1;
            m_room[i] = cmd_room; m_func[i] = cmd_func;
          end else begin
            m_erp[i] = 1'b1;
          end
        end else if (p == P_DRAW) begin
          if (draw_done) m_e[i] = m_n;
          else if (m_n - (m_s[i] + 3) == tmo(i) - 1) m_txn[i] = 1'b0;
        end else if (p == P_UPD) begin
          m_lock[i][m_room[i]] = m_func[i];
          m_txn[i] = 1'b0;
          m_e[i]   = -1;
        end
      end
      m_n++;
    end
  end

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [22:0] ev, ov;
        ev = expv(i);
        ov = obsv(i);
        total++;
        if (ov !== ev) begin
          bad++;
          $display("FAIL cycle_check inst=%0d n=%0d got=%06h want=%06h", i, m_n, ov, ev);
        end
        if (o_pulse[i] === 1'b1) pulse_cnt[i]++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] r, input logic f);
    cmd_valid = 1'b1;
    cmd_room  = r;
    cmd_func  = f;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    while (o_start[1] !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("draw_start_seen", o_start[1], 1);
  endtask

  task automatic txn(input logic [2:0] r, input logic f, input int dly);
    int k;
    send(r, f);
    wait_start(k);
    repeat (dly) tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    int k;
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_clear", o_clr[1], 1);
    check("rst_ready", o_ready[1], 0);
    check("rst_busy", o_busy[1], 1);
    check("rst_lock", o_lock[1], 0);

    // Clear phase; a command in the middle of it must be ignored
    @(negedge clock);
    reset = 1'b1;
    for (int c = 1; c <= CLR; c++) begin
      tick();
      cmd_valid = (c == 5);
      cmd_room  = 3'd2;
      cmd_func  = 1'b1;
      if (c == CLR - 1) begin
        check("clear_last", o_clr[1], 1);
        check("not_ready_yet", o_ready[1], 0);
      end
      if (c == CLR) begin
        check("ready_after_clear", o_ready[1], 1);
        check("clear_dropped", o_clr[1], 0);
      end
    end
    check("init_cmd_ignored", o_sroom[1], 0);

    // Room 3 lock; draw_done 10 cycles after draw_start (times out in the short instance)
    send(3'd3, 1'b1);
    wait_start(k);
    check("latency", 1 + k, 4);
    check("enable_at_start", o_en[1], 5'b01000);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == TO_A - 1) check("a_timeout_pulse", o_eto[0], 1);
      if (c == TO_A) check("a_ready_after_to", o_ready[0], 1);
      if (c == 10) check("b_enable_in_draw", o_en[1], 5'b01000);
    end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    tick();
    check("b_lock_r3", o_lock[1], 5'b01000);
    check("a_lock_unchanged", o_lock[0], 5'b00000);
    check("b_ready_after_upd", o_ready[1], 1);

    // Invalid room
    send(3'd6, 1'b1);
    check("err_room_pulse", o_erm[1], 1);
    check("err_room_noload", o_load[1], 0);
    check("err_room_idle", o_ready[1], 1);
    tick();
    check("err_room_single", o_erm[1], 0);
    check("err_room_sel_kept", o_sroom[1], 3);

    // draw_done on the short instance's timeout cycle counts as done
    txn(3'd1, 1'b1, TO_A - 1);
    check("a_done_at_timeout", o_lock[0], 5'b00010);
    check("b_lock_r1", o_lock[1], 5'b01010);

    // Lock every room, then unlock room 2
    for (int r = 0; r < 5; r++) txn(3'(r), 1'b1, 2);
    tick();
    check("all_locked_b", o_all[1], 1);
    check("pulse_once_b", pulse_cnt[1], 1);
    check("pulse_once_a", pulse_cnt[0], 1);
    txn(3'd2, 1'b0, 2);
    tick();
    check("unlock_r2", o_lock[1], 5'b11011);
    check("all_locked_clear", o_all[1], 0);
    check("no_extra_pulse", pulse_cnt[1], 1);

    // Command during DRAW is dropped; reset mid-DRAW aborts
    send(3'd1, 1'b1);
    wait_start(k);
    tick();
    cmd_valid = 1'b1;
    cmd_room  = 3'd0;
    cmd_func  = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("drop_sel_room", o_sroom[1], 1);
    check("drop_busy", o_busy[1], 1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_busy", o_busy[1], 1);
    check("arst_ready", o_ready[1], 0);
    check("arst_enable", o_en[1], 0);
    check("arst_clear", o_clr[1], 1);
    check("arst_lock", o_lock[1], 0);
    check("arst_sel", o_sroom[1], 0);
    check("arst_eto", o_eto[1], 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (CLR + 2) tick();
    check("ready_after_rst", o_ready[1], 1);
    txn(3'd4, 1'b1, 0);
    check("lock_r4_first_cycle_done", o_lock[1], 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
